// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/decode, branch, stall and start/done signals between the sequencer and its core.
interface pc_sequencer_if;
  logic        start;
  logic        format;
  logic [3:0]  opcode;
  logic        sign;
  logic [2:0]  operand;
  logic        stall;
  logic        br_cond;
  logic [15:0] br_target;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic [15:0] retired;
  modport master (
    input  start, format, opcode, sign, operand, stall, br_cond, br_target,
    output pc_out, instr_valid, busy, done, retired
  );
  modport slave (
    output start, format, opcode, sign, operand, stall, br_cond, br_target,
    input  pc_out, instr_valid, busy, done, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer with branch, stall, halt and retired-count tracking.
module pc_sequencer #(
  parameter logic        HALT_FMT    = 1'b1,
  parameter logic [3:0]  HALT_OPCODE = 4'hB,
  parameter logic [3:0]  BR_OPCODE   = 4'h3,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic is_halt, is_br;
  logic [15:0] ret_next;
  assign is_halt = bus.format == HALT_FMT && bus.opcode == HALT_OPCODE && !bus.sign && bus.operand == 3'b000;
  assign is_br = bus.format && bus.opcode == BR_OPCODE;
  assign ret_next = bus.retired == 16'hFFFF ? bus.retired : bus.retired + 16'd1;
  assign bus.busy = state == RUN;
  assign bus.instr_valid = state == RUN;
  assign bus.done = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.pc_out  <= RESET_PC;
      bus.retired <= 16'd0;
    end else if (state != RUN) begin
      if (bus.start) begin
        state       <= RUN;
        bus.pc_out  <= RESET_PC;
        bus.retired <= 16'd0;
      end
    end else if (!bus.stall) begin
      bus.retired <= ret_next;
      if (is_halt) state <= HALT;
      else bus.pc_out <= is_br && bus.br_cond ? bus.br_target : bus.pc_out + 16'd1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests for pc_sequencer with a behavioural combinational ROM.
module tb_pc_sequencer;
  localparam logic [8:0] NOP = 9'b0_0000_0_000;
  localparam logic [8:0] HLT = 9'b1_1011_0_000;
  localparam logic [8:0] BR  = 9'b1_0011_0_000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] rom [0:65535];
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always_comb {bus.format, bus.opcode, bus.sign, bus.operand} = rom[bus.pc_out];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    if (obs === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.instr_valid, bus.busy, bus.done}, {29'd0, exp});
  endtask
  task automatic run_to(input logic [15:0] a);
    int n;
    n = 0;
    while (bus.pc_out != a && n < 200) begin
      tick();
      n++;
    end
    check("run_to", bus.pc_out, a);
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = NOP;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.br_cond = 1'b0;
    bus.br_target = 16'd0;
    repeat (2) tick();
    check("rst_pc", bus.pc_out, 16'd0);
    check("rst_ret", bus.retired, 16'd0);
    flags("rst_flags", 3'b000);
    reset = 1'b0;
    tick();
    flags("idle_flags", 3'b000);
    rom[5] = HLT;
    do_start();
    check("start_pc", bus.pc_out, 16'd0);
    flags("start_flags", 3'b110);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("seq_pc", bus.pc_out, i);
    end
    tick();
    flags("halt_flags", 3'b001);
    check("halt_pc", bus.pc_out, 16'd5);
    check("halt_ret", bus.retired, 16'd6);
    tick();
    check("halt_hold_pc", bus.pc_out, 16'd5);
    check("halt_hold_ret", bus.retired, 16'd6);
    rom[5] = NOP;
    do_start();
    check("restart_pc", bus.pc_out, 16'd0);
    check("restart_ret", bus.retired, 16'd0);
    flags("restart_flags", 3'b110);
    run_to(16'd7);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc_out, 16'd7);
      check("stall_ret", bus.retired, 16'd7);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_pc", bus.pc_out, 16'd8);
    check("unstall_ret", bus.retired, 16'd8);
    rom[19] = BR;
    run_to(16'd19);
    bus.br_cond = 1'b1;
    bus.br_target = 16'd30;
    tick();
    check("br_taken_pc", bus.pc_out, 16'd30);
    rom[30] = BR;
    bus.br_target = 16'hFFFF;
    tick();
    bus.br_cond = 1'b0;
    check("br_ffff_pc", bus.pc_out, 16'hFFFF);
    tick();
    check("wrap_pc", bus.pc_out, 16'd0);
    check("wrap_ret", bus.retired, 16'd22);
    rom[1] = HLT;
    tick();
    check("pre_halt_pc", bus.pc_out, 16'd1);
    bus.stall = 1'b1;
    repeat (2) tick();
    flags("stalled_halt_flags", 3'b110);
    check("stalled_halt_pc", bus.pc_out, 16'd1);
    bus.stall = 1'b0;
    tick();
    flags("halt2_flags", 3'b001);
    check("halt2_ret", bus.retired, 16'd24);
    check("halt2_pc", bus.pc_out, 16'd1);
    rom[1] = NOP;
    rom[3] = 9'b1_1011_0_001;
    rom[4] = 9'b1_1011_1_000;
    rom[12] = BR;
    do_start();
    check("run3_ret", bus.retired, 16'd0);
    run_to(16'd12);
    flags("near_halt_flags", 3'b110);
    bus.br_target = 16'd30;
    tick();
    check("br_not_taken12", bus.pc_out, 16'd13);
    run_to(16'd19);
    tick();
    check("br_not_taken19", bus.pc_out, 16'd20);
    check("run3_ret20", bus.retired, 16'd20);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_in_run_pc", bus.pc_out, 16'd21);
    check("start_in_run_ret", bus.retired, 16'd21);
    rom[21] = BR;
    bus.br_cond = 1'b1;
    bus.br_target = 16'd12;
    tick();
    check("br_back_pc", bus.pc_out, 16'd12);
    bus.br_target = 16'd30;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.br_cond = 1'b0;
    check("midrst_pc", bus.pc_out, 16'd0);
    check("midrst_ret", bus.retired, 16'd0);
    flags("midrst_flags", 3'b000);
    tick();
    flags("midrst_idle", 3'b000);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the 9-bit single-cycle core. It drives the 16-bit `pc_in` address of the instruction ROM and consumes the decoded `format`/`opcode`/`sign`/`operand` fields that the ROM returns combinationally. It resolves taken branches from the datapath, honours datapath stalls, and detects the halt instruction. It exposes start/done handshaking and a retired-instruction counter to the testbench/top level.

## Interface

- `HALT_FMT`, 1'b1: `format` value of the halt instruction.
- `HALT_OPCODE`, 4'hB: `opcode` of the halt instruction; halt additionally requires `sign`=0 and `operand`=3'b000, i.e. instruction 9'b1_1011_0_000.
- `BR_OPCODE`, 4'h3: `opcode`, with `format`=1, that marks a branch instruction.
- `RESET_PC`, 16'h0000: PC loaded on reset and on every start.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle pulse; begins execution from `RESET_PC`.
- `format`, input, 1: decoded format bit from the ROM for the current `pc_out`.
- `opcode`, input, 4: decoded opcode from the ROM.
- `sign`, input, 1: decoded sign bit from the ROM.
- `operand`, input, 3: decoded operand field from the ROM.
- `stall`, input, 1: datapath cannot retire the current instruction this cycle.
- `br_cond`, input, 1: branch condition from the datapath, valid in the cycle a branch instruction is presented.
- `br_target`, input, 16: absolute branch target from the datapath register file.
- `pc_out`, output, 16: registered fetch address, wired to ROM `pc_in`.
- `instr_valid`, output, 1: the ROM output for `pc_out` is live and may be executed this cycle.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in HALT.
- `retired`, output, 16: count of instructions retired since the last start.

## Operation

- States: IDLE, RUN, HALT. Reset enters IDLE.
- **IDLE**
  - `pc_out`=`RESET_PC`; `instr_valid`=0.
  - `start` → RUN; `pc_out`←`RESET_PC`; `retired`←0.
- **RUN**
  - `instr_valid`=1 every cycle.
  - The instruction at `pc_out` retires on a rising edge when `stall`=0.
  - Next-PC priority, evaluated only on a retiring cycle:
    1. Halt decode → go to HALT; `pc_out` holds (points at the halt instruction); `retired`+1.
    2. Branch decode (`format`=1, `opcode`=`BR_OPCODE`) with `br_cond`=1 → `pc_out`←`br_target`.
    3. Otherwise `pc_out`←`pc_out`+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - `stall`=1 → `pc_out`, state and `retired` hold; the halt/branch decode is ignored that cycle.
  - `start` is ignored in RUN.
- **HALT**
  - `done`=1; `instr_valid`=0; `pc_out` and `retired` hold.
  - `start` → RUN with `pc_out`←`RESET_PC` and `retired`←0.
- **retired counter**
  - Increments by 1 per retiring cycle, including the halt instruction and taken branches.
  - Saturates at 16'hFFFF.
- Branch decode with `br_cond`=0 is an ordinary PC+1 retire.
- `br_target` is used unmodified; there is no alignment or range check.
- ROM addresses the program does not populate are the program's responsibility; the sequencer does not detect them.

## Timing

- All outputs are registered, or derived purely from the state register; there are no combinational input-to-output paths.
- Reset values: `pc_out`=`RESET_PC`, `instr_valid`=0, `busy`=0, `done`=0, `retired`=0, state=IDLE.
- Reset takes effect at the first rising edge with `reset`=1 and overrides `start`, `stall` and any decode in that cycle. This applies mid-RUN and in HALT alike.
- `start` sampled at edge N → `busy`=1, `instr_valid`=1 and `pc_out`=`RESET_PC` from cycle N+1.
- Fetch is single-cycle: the ROM is combinational on `pc_out`, and decode inputs are sampled at the same edge that advances `pc_out`.
- A taken branch has zero-bubble latency: the target appears on `pc_out` in the cycle after the branch retires.
- Halt retired at edge N → `done`=1 and `busy`=0 from cycle N+1.
- `stall` held for k cycles delays the retire by exactly k cycles.

## Test plan

- **Reset/start:** hold `reset` 2 cycles, then pulse `start` → `pc_out`=0, `instr_valid`=1, `busy`=1 next cycle; `done`=0.
- **Sequential + halt:** ROM holds 5 non-branch instructions, then halt at address 5 → `pc_out` steps 0..5; `done`=1 on the cycle after address 5 retires; `retired`=6; `pc_out` stays 5.
- **Branch taken/not-taken:**
  - Branch at `pc_out`=19 with `br_cond`=1, `br_target`=16'd30 → next `pc_out`=30.
  - Same branch with `br_cond`=0 → next `pc_out`=20.
- **Stall:**
  - Assert `stall` for 3 cycles at `pc_out`=7 → `pc_out` stays 7 for 4 cycles total, then 8; `retired` rises by exactly 1.
  - Halt presented under `stall` → no transition to HALT until `stall` drops.
- **Wrap and restart:**
  - Branch to 16'hFFFF, non-branch there → `pc_out` wraps to 0.
  - After halt, pulse `start` → `retired`=0 and `pc_out`=0.
- **Reset mid-run:** assert `reset` at `pc_out`=12 while a taken branch is presented → next cycle IDLE, `pc_out`=0, `retired`=0, all flags 0.
